// File: rtl/tag_free_list.sv
// tag_free_list
//   Circular FIFO of free rename/ROB tags. The dispatcher pops one tag per
//   register-writing instruction; the CDB returns tags on each valid
//   broadcast. A per-tag free bitmap catches returns of tags that are
//   already free. The list comes out of reset holding every tag, 0 first.
//
// Ports
//   clk                 rising-edge clock
//   rst                 asynchronous, active-high reset
//   dispatch_tag_rd_en  consume the tag on tag_out this cycle
//   tag_out             head tag, first-word-fall-through (valid when !tag_empty)
//   tag_empty           no free tag available (registered)
//   tag_count           number of free tags, 0..NUM_TAGS (registered)
//   cdb_valid           CDB broadcast valid, returns cdb_tag
//   cdb_tag             tag being released
//   dup_err             sticky flag: a return of an already-free tag was seen
module tag_free_list #(
  parameter int TAG_WIDTH = 6,
  parameter int NUM_TAGS  = 64,
  parameter int CNT_WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dispatch_tag_rd_en,
  output logic [TAG_WIDTH-1:0] tag_out,
  output logic                 tag_empty,
  output logic [CNT_WIDTH-1:0] tag_count,
  input  logic                 cdb_valid,
  input  logic [TAG_WIDTH-1:0] cdb_tag,
  output logic                 dup_err
);

  logic [TAG_WIDTH-1:0] mem [NUM_TAGS];
  logic [TAG_WIDTH-1:0] rd_ptr;
  logic [TAG_WIDTH-1:0] wr_ptr;
  logic [NUM_TAGS-1:0]  free_map;

  logic                 rd_fire;
  logic                 ret_legal;
  logic                 ret_dup;
  logic [CNT_WIDTH-1:0] count_next;

  // Head of the list is a plain read mux on registered state.
  assign tag_out = mem[rd_ptr];

  // Legality uses the bitmap as it stands before the edge, so returning the
  // tag being popped in the same cycle is seen as a duplicate. A read always
  // clears a currently-free tag and a legal return always sets a currently
  // non-free one, so the two bitmap updates never touch the same bit.
  always_comb begin
    rd_fire    = dispatch_tag_rd_en && !tag_empty;
    ret_legal  = cdb_valid && !free_map[cdb_tag];
    ret_dup    = cdb_valid &&  free_map[cdb_tag];
    count_next = tag_count
               + {{(CNT_WIDTH-1){1'b0}}, ret_legal}
               - {{(CNT_WIDTH-1){1'b0}}, rd_fire};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        mem[i] <= TAG_WIDTH'(i);
      end
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      free_map  <= '1;
      tag_count <= CNT_WIDTH'(NUM_TAGS);
      tag_empty <= 1'b0;
      dup_err   <= 1'b0;
    end else begin
      if (rd_fire) begin
        rd_ptr            <= rd_ptr + 1'b1;
        free_map[tag_out] <= 1'b0;
      end
      if (ret_legal) begin
        mem[wr_ptr]       <= cdb_tag;
        wr_ptr            <= wr_ptr + 1'b1;
        free_map[cdb_tag] <= 1'b1;
      end
      if (ret_dup) begin
        dup_err <= 1'b1;
      end
      tag_count <= count_next;
      tag_empty <= (count_next == '0);
    end
  end

endmodule

// File: tb/tb_tag_free_list.sv
// tb_tag_free_list
//   Self-checking bench for tag_free_list. A queue of free tags in expected
//   FIFO order plus an outstanding-tag array form the scoreboard: returned
//   tags are pushed when the return is driven, and the head is popped and
//   compared against tag_out when the dispatcher consumes it.
module tb_tag_free_list;

  logic       clk;
  logic       rst;
  logic       dispatch_tag_rd_en;
  logic [5:0] tag_out;
  logic       tag_empty;
  logic [6:0] tag_count;
  logic       cdb_valid;
  logic [5:0] cdb_tag;
  logic       dup_err;

  int n_checks;
  int n_fail;

  int fq[$];
  bit outst[64];
  bit mdup;

  tag_free_list #(.TAG_WIDTH(6), .NUM_TAGS(64), .CNT_WIDTH(7)) dut (
    .clk                (clk),
    .rst                (rst),
    .dispatch_tag_rd_en (dispatch_tag_rd_en),
    .tag_out            (tag_out),
    .tag_empty          (tag_empty),
    .tag_count          (tag_count),
    .cdb_valid          (cdb_valid),
    .cdb_tag            (cdb_tag),
    .dup_err            (dup_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    fq.delete();
    for (int i = 0; i < 64; i++) begin
      fq.push_back(i);
      outst[i] = 1'b0;
    end
    mdup = 1'b0;
  endtask

  // Called at a negedge: drive one cycle of stimulus, update the scoreboard
  // with the pre-edge view, then return at the following negedge with inputs idle.
  task automatic step(input bit rd, input bit v, input int t);
    bit legal;
    int h;
    dispatch_tag_rd_en = rd;
    cdb_valid          = v;
    cdb_tag            = t[5:0];
    legal = v && outst[t];
    if (rd && fq.size() > 0) begin
      h = fq.pop_front();
      outst[h] = 1'b1;
    end
    if (v) begin
      if (legal) begin
        fq.push_back(t);
        outst[t] = 1'b0;
      end else begin
        mdup = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    dispatch_tag_rd_en = 1'b0;
    cdb_valid          = 1'b0;
    cdb_tag            = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (tag_count !== 7'd64) begin n_fail++; $display("FAIL reset_count: got %0d expected 64", tag_count); end
    n_checks++;
    if (tag_empty !== 1'b0) begin n_fail++; $display("FAIL reset_empty: got %0b expected 0", tag_empty); end
    n_checks++;
    if (tag_out !== 6'd0) begin n_fail++; $display("FAIL reset_tag_out: got %0d expected 0", tag_out); end
    n_checks++;
    if (dup_err !== 1'b0) begin n_fail++; $display("FAIL reset_dup: got %0b expected 0", dup_err); end
  endtask

  task automatic test_read3();
    int exp_t;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_t = fq[0];
      n_checks++;
      if (tag_out !== exp_t[5:0]) begin n_fail++; $display("FAIL read3_tag[%0d]: got %0d expected %0d", i, tag_out, exp_t); end
      n_checks++;
      if (tag_empty !== 1'b0) begin n_fail++; $display("FAIL read3_empty[%0d]: got %0b expected 0", i, tag_empty); end
      step(1, 0, 0);
    end
    n_checks++;
    if (tag_count !== 7'd61) begin n_fail++; $display("FAIL read3_count: got %0d expected 61", tag_count); end
    n_checks++;
    if (tag_out !== 6'd3) begin n_fail++; $display("FAIL read3_head: got %0d expected 3", tag_out); end
  endtask

  task automatic test_drain_refill();
    int exp_t;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      exp_t = fq[0];
      n_checks++;
      if (tag_out !== exp_t[5:0]) begin n_fail++; $display("FAIL drain_tag[%0d]: got %0d expected %0d", i, tag_out, exp_t); end
      step(1, 0, 0);
    end
    n_checks++;
    if (tag_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %0b expected 1", tag_empty); end
    n_checks++;
    if (tag_count !== 7'd0) begin n_fail++; $display("FAIL drain_count: got %0d expected 0", tag_count); end
    step(1, 0, 0);
    step(1, 0, 0);
    n_checks++;
    if (tag_empty !== 1'b1 || tag_count !== 7'd0) begin
      n_fail++; $display("FAIL drain_overread: got empty=%0b count=%0d expected empty=1 count=0", tag_empty, tag_count);
    end
    // Return 17 while still requesting a read: the read stays ignored.
    step(1, 1, 17);
    n_checks++;
    if (tag_empty !== 1'b0) begin n_fail++; $display("FAIL refill_empty: got %0b expected 0", tag_empty); end
    n_checks++;
    if (tag_out !== 6'd17) begin n_fail++; $display("FAIL refill_tag: got %0d expected 17", tag_out); end
    n_checks++;
    if (tag_count !== 7'd1) begin n_fail++; $display("FAIL refill_count: got %0d expected 1", tag_count); end
    n_checks++;
    if (dup_err !== 1'b0) begin n_fail++; $display("FAIL refill_dup: got %0b expected 0", dup_err); end
  endtask

  task automatic test_return_order();
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    n_checks++;
    if (tag_count !== 7'd60) begin n_fail++; $display("FAIL order_count_a: got %0d expected 60", tag_count); end
    step(1, 1, 2);
    n_checks++;
    if (tag_count !== 7'd60) begin n_fail++; $display("FAIL order_count_b: got %0d expected 60", tag_count); end
    step(0, 1, 0);
    n_checks++;
    if (tag_count !== 7'd61) begin n_fail++; $display("FAIL order_count_c: got %0d expected 61", tag_count); end
    for (int i = 0; i < 59; i++) step(1, 0, 0);
    n_checks++;
    if (tag_out !== 6'd2) begin n_fail++; $display("FAIL order_head_2: got %0d expected 2", tag_out); end
    step(1, 0, 0);
    n_checks++;
    if (tag_out !== 6'd0) begin n_fail++; $display("FAIL order_head_0: got %0d expected 0", tag_out); end
    n_checks++;
    if (dup_err !== 1'b0) begin n_fail++; $display("FAIL order_dup: got %0b expected 0", dup_err); end
  endtask

  task automatic test_dup_full_and_async_reset();
    do_reset();
    step(0, 1, 5);
    n_checks++;
    if (dup_err !== 1'b1) begin n_fail++; $display("FAIL full_dup: got %0b expected 1", dup_err); end
    n_checks++;
    if (tag_count !== 7'd64) begin n_fail++; $display("FAIL full_count: got %0d expected 64", tag_count); end
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    n_checks++;
    if (tag_count !== 7'd54 || tag_out !== 6'd10) begin
      n_fail++; $display("FAIL pre_rst_state: got count=%0d tag=%0d expected count=54 tag=10", tag_count, tag_out);
    end
    // Reset asserted between clock edges must act without waiting for clk.
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (dup_err !== 1'b0) begin n_fail++; $display("FAIL async_rst_dup: got %0b expected 0", dup_err); end
    n_checks++;
    if (tag_count !== 7'd64) begin n_fail++; $display("FAIL async_rst_count: got %0d expected 64", tag_count); end
    n_checks++;
    if (tag_out !== 6'd0) begin n_fail++; $display("FAIL async_rst_tag: got %0d expected 0", tag_out); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_same_tag();
    do_reset();
    for (int i = 0; i < 7; i++) step(1, 0, 0);
    n_checks++;
    if (tag_out !== 6'd7 || tag_count !== 7'd57) begin
      n_fail++; $display("FAIL same_pre: got tag=%0d count=%0d expected tag=7 count=57", tag_out, tag_count);
    end
    step(1, 1, 7);
    n_checks++;
    if (dup_err !== 1'b1) begin n_fail++; $display("FAIL same_dup: got %0b expected 1", dup_err); end
    n_checks++;
    if (tag_count !== 7'd56) begin n_fail++; $display("FAIL same_count: got %0d expected 56", tag_count); end
    n_checks++;
    if (tag_out !== 6'd8) begin n_fail++; $display("FAIL same_head: got %0d expected 8", tag_out); end
  endtask

  task automatic test_random();
    int nout, r, t, exp_t;
    bit rd, v;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      nout = 64 - fq.size();
      n_checks++;
      if (tag_count !== 7'(fq.size())) begin n_fail++; $display("FAIL rnd_count@%0d: got %0d expected %0d", c, tag_count, fq.size()); end
      n_checks++;
      if (tag_empty !== (fq.size() == 0)) begin n_fail++; $display("FAIL rnd_empty@%0d: got %0b expected %0b", c, tag_empty, fq.size() == 0); end
      n_checks++;
      if (dup_err !== 1'b0) begin n_fail++; $display("FAIL rnd_dup@%0d: got %0b expected 0", c, dup_err); end
      if (fq.size() > 0) begin
        exp_t = fq[0];
        n_checks++;
        if (tag_out !== exp_t[5:0]) begin n_fail++; $display("FAIL rnd_tag@%0d: got %0d expected %0d", c, tag_out, exp_t); end
        n_checks++;
        if (outst[tag_out]) begin n_fail++; $display("FAIL rnd_reissue@%0d: got tag %0d already outstanding, expected a free tag", c, tag_out); end
      end
      rd = ($urandom_range(0, 1) == 1);
      v  = (nout > 0) && ($urandom_range(0, 1) == 1);
      t  = 0;
      if (v) begin
        r = $urandom_range(0, 63);
        for (int k = 0; k < 64; k++) begin
          if (outst[(r + k) % 64]) begin
            t = (r + k) % 64;
            break;
          end
        end
      end
      step(rd, v, t);
    end
  endtask

  initial begin
    n_checks           = 0;
    n_fail             = 0;
    rst                = 1'b1;
    dispatch_tag_rd_en = 1'b0;
    cdb_valid          = 1'b0;
    cdb_tag            = '0;
    model_reset();
    test_reset();
    test_read3();
    test_drain_refill();
    test_return_order();
    test_dup_full_and_async_reset();
    test_same_tag();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
